// File: rtl/mod_writeback.sv
// Writeback stage: EX/WB register, single-port register-file writes with two-cycle
// IMUL (RAX then RDX), RFLAGS commit, jump redirects and end-of-program halt.
module mod_writeback #(
  parameter int              DATA_W       = 64,
  parameter int              NREGS        = 16,
  parameter logic [DATA_W-1:0] RFLAGS_RESET = 64'h2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ex_valid,
  output logic                       wb_ready,
  input  logic [DATA_W-1:0]          ex_rip,
  input  logic [1:0]                 ex_dep,
  input  logic [$clog2(NREGS)-1:0]   ex_regbyte,
  input  logic [$clog2(NREGS)-1:0]   ex_rmbyte,
  input  logic [7:0]                 ex_opcode,
  input  logic [DATA_W-1:0]          ex_result,
  input  logic [DATA_W-1:0]          ex_ext_result,
  input  logic [DATA_W-1:0]          ex_flags,
  input  logic                       ex_flags_we,
  input  logic                       ex_jump,
  input  logic [DATA_W-1:0]          ex_jump_target,
  input  logic                       ex_sim_end,
  output logic                       rf_we,
  output logic [$clog2(NREGS)-1:0]   rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [DATA_W-1:0]          rflags_seq,
  output logic                       retire_valid,
  output logic [DATA_W-1:0]          retire_rip,
  output logic                       redirect_valid,
  output logic [DATA_W-1:0]          redirect_pc,
  output logic                       sim_end_out
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {IDLE, WRITE, WRITE_HI, HALT} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rip;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] ext_result;
    logic [DATA_W-1:0] flags;
    logic [DATA_W-1:0] jump_target;
    logic [AW-1:0]     dest;
    logic [7:0]        opcode;
    logic              we;
    logic              flags_we;
    logic              jump;
    logic              sim_end;
  } exwb_t;

  state_t            state_q, state_d;
  exwb_t             exwb_q, exwb_d;
  logic [DATA_W-1:0] rflags_q, rflags_d;
  logic              is_imul;
  logic              accept;
  logic              dec_we;
  logic [AW-1:0]     dec_dest;

  assign is_imul = (exwb_q.opcode == 8'hF7);

  // Destination and write-suppression decode happen at capture time
  always_comb begin
    dec_dest = (ex_dep == 2'd2) ? ex_regbyte : ex_rmbyte;
    if (ex_opcode == 8'h0D) dec_dest = '0;
    dec_we = 1'b1;
    if (ex_opcode == 8'h74 || ex_opcode == 8'h7D) dec_we = 1'b0;
    if ((ex_opcode == 8'h80 || ex_opcode == 8'h81 || ex_opcode == 8'h83) &&
        ex_regbyte == AW'(7)) dec_we = 1'b0;
  end

  always_comb begin
    state_d        = state_q;
    exwb_d         = exwb_q;
    rflags_d       = rflags_q;
    wb_ready       = 1'b0;
    accept         = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    retire_valid   = 1'b0;
    retire_rip     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    sim_end_out    = 1'b0;

    case (state_q)
      IDLE: begin
        wb_ready = 1'b1;
      end
      WRITE: begin
        wb_ready     = !is_imul;
        rf_we        = exwb_q.we;
        rf_waddr     = is_imul ? '0 : exwb_q.dest;
        rf_wdata     = exwb_q.result;
        retire_valid = !is_imul;
      end
      WRITE_HI: begin
        wb_ready     = 1'b1;
        rf_we        = 1'b1;
        rf_waddr     = AW'(2);
        rf_wdata     = exwb_q.ext_result;
        retire_valid = 1'b1;
      end
      default: begin
        sim_end_out = 1'b1;
      end
    endcase

    if (retire_valid) begin
      retire_rip = exwb_q.rip;
      if (exwb_q.opcode == 8'h74 && exwb_q.jump) begin
        redirect_valid = 1'b1;
        redirect_pc    = exwb_q.jump_target;
      end
      if (exwb_q.flags_we) begin
        rflags_d    = exwb_q.flags;
        rflags_d[1] = 1'b1;
        rflags_d[3] = 1'b0;
        rflags_d[5] = 1'b0;
      end
    end

    // Halting wins over a same-cycle accept: nothing may follow the end marker
    if (state_q == WRITE && is_imul) begin
      state_d = WRITE_HI;
    end else if (retire_valid && exwb_q.sim_end) begin
      state_d = HALT;
    end else if (state_q != HALT) begin
      accept  = ex_valid && wb_ready;
      state_d = accept ? WRITE : IDLE;
    end

    if (accept) begin
      exwb_d.rip         = ex_rip;
      exwb_d.result      = ex_result;
      exwb_d.ext_result  = ex_ext_result;
      exwb_d.flags       = ex_flags;
      exwb_d.jump_target = ex_jump_target;
      exwb_d.dest        = dec_dest;
      exwb_d.opcode      = ex_opcode;
      exwb_d.we          = dec_we;
      exwb_d.flags_we    = ex_flags_we;
      exwb_d.jump        = ex_jump;
      exwb_d.sim_end     = ex_sim_end;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      exwb_q   <= '0;
      rflags_q <= RFLAGS_RESET;
    end else begin
      state_q  <= state_d;
      exwb_q   <= exwb_d;
      rflags_q <= rflags_d;
    end
  end

  assign rflags_seq = rflags_q;

endmodule
